// File: rtl/pe_fu_ctrl_pkg.sv
// Shared types and field constants for the RipTide PE functional-unit controller.
package pe_fu_ctrl_pkg;

   localparam int unsigned PE_OP_W       = 4;
   localparam int unsigned PE_TRIP_W     = 8;
   localparam int unsigned CFG_BCONST_B  = 4;
   localparam int unsigned CFG_TRIP_LSB  = 8;

   typedef enum logic [2:0] {
      S_CFG   = 3'd0,
      S_RUN   = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } pe_ctrl_state_e;

   typedef struct packed {
      logic [PE_TRIP_W-1:0] trip;
      logic                 b_const;
      logic [PE_OP_W-1:0]   op;
   } pe_cfg0_t;

endpackage

// File: rtl/pe_fu_ctrl_if.sv
// Channel bundle between the PE controller and its environment.
// PE_FU_CTRL_PERF_EN adds the performance counter outputs.
interface pe_fu_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   import pe_fu_ctrl_pkg::*;

   logic                  clear;
   logic                  cfg_valid;
   logic [DATA_WIDTH-1:0] cfg_data;
   logic                  cfg_ready;
   logic                  cfgd;
   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  b_ready;
   logic                  fu_in_valid;
   logic [DATA_WIDTH-1:0] fu_in_a;
   logic [DATA_WIDTH-1:0] fu_in_b;
   logic [PE_OP_W-1:0]    fu_op;
   logic                  fu_ready;
   logic                  fu_done;
   logic [DATA_WIDTH-1:0] fu_out;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic                  done;
`ifdef PE_FU_CTRL_PERF_EN
   logic [31:0]           perf_fire;
   logic [31:0]           perf_stall;
`endif

   modport slave (
      input  clear, cfg_valid, cfg_data, a_valid, a_data, b_valid, b_data,
             fu_ready, fu_done, fu_out, out_ready,
      output cfg_ready, cfgd, a_ready, b_ready, fu_in_valid, fu_in_a, fu_in_b,
             fu_op, out_valid, out_data, done
`ifdef PE_FU_CTRL_PERF_EN
      , output perf_fire, perf_stall
`endif
   );

   modport master (
      output clear, cfg_valid, cfg_data, a_valid, a_data, b_valid, b_data,
             fu_ready, fu_done, fu_out, out_ready,
      input  cfg_ready, cfgd, a_ready, b_ready, fu_in_valid, fu_in_a, fu_in_b,
             fu_op, out_valid, out_data, done
`ifdef PE_FU_CTRL_PERF_EN
      , input perf_fire, perf_stall
`endif
   );

endinterface

// File: rtl/pe_out_fifo.sv
// Small power-of-two result queue with occupancy count and synchronous flush.
module pe_out_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pe_fu_ctrl.sv
// Sequencing controller for one RipTide PE functional unit: config load,
// operand gather, single-issue to the FU, and a reserved-slot output queue.
// PE_FU_CTRL_PERF_EN adds saturating issue/stall counters.
module pe_fu_ctrl
   import pe_fu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OUT_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   pe_fu_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

   pe_ctrl_state_e        state;
   logic                  cfg_idx;
   pe_cfg0_t              cfg0;
   logic [DATA_WIDTH-1:0] b_cst;
   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic                  a_held;
   logic                  b_held;
   logic [PE_TRIP_W-1:0]  fire_cnt;
   logic                  cfg_ready;
   logic                  cfgd;
   logic                  a_ready;
   logic                  b_ready;
   logic                  done;

   logic [CNT_W-1:0]      q_count;
   logic                  q_empty;
   logic                  q_full;
   logic [DATA_WIDTH-1:0] q_head;

   logic                  ops_ready;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  drain_last;
   logic                  trip_hit;

   // Only one op is ever in flight, so a non-full queue at issue reserves its slot.
   assign ops_ready  = a_held && (b_held || cfg0.b_const);
   assign issue      = (state == S_RUN) && ops_ready && bus.fu_ready && !q_full;
   assign push       = (state == S_WAIT) && bus.fu_done;
   assign pop        = !q_empty && bus.out_ready;
   assign drain_last = q_empty || ((q_count == CNT_W'(1)) && pop);
   assign trip_hit   = (cfg0.trip != '0) && (fire_cnt == cfg0.trip);

   pe_out_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.clear),
      .push  (push),
      .din   (bus.fu_out),
      .pop   (pop),
      .dout  (q_head),
      .count (q_count),
      .empty (q_empty),
      .full  (q_full)
   );

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         state     <= S_CFG;
         cfg_idx   <= 1'b0;
         cfg0      <= '0;
         b_cst     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         a_held    <= 1'b0;
         b_held    <= 1'b0;
         fire_cnt  <= '0;
         cfg_ready <= 1'b1;
         cfgd      <= 1'b0;
         a_ready   <= 1'b0;
         b_ready   <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_CFG: begin
               if (bus.cfg_valid) begin
                  if (!cfg_idx) begin
                     cfg0.op      <= bus.cfg_data[PE_OP_W-1:0];
                     cfg0.b_const <= bus.cfg_data[CFG_BCONST_B];
                     cfg0.trip    <= bus.cfg_data[CFG_TRIP_LSB +: PE_TRIP_W];
                     cfg_idx      <= 1'b1;
                  end else begin
                     b_cst     <= bus.cfg_data;
                     cfg_ready <= 1'b0;
                     cfgd      <= 1'b1;
                     a_ready   <= 1'b1;
                     b_ready   <= !cfg0.b_const;
                     state     <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (bus.a_valid && a_ready) begin
                  a_reg   <= bus.a_data;
                  a_held  <= 1'b1;
                  a_ready <= 1'b0;
               end
               if (bus.b_valid && b_ready) begin
                  b_reg   <= bus.b_data;
                  b_held  <= 1'b1;
                  b_ready <= 1'b0;
               end
               if (issue) begin
                  a_held <= 1'b0;
                  b_held <= 1'b0;
                  if (fire_cnt != '1) fire_cnt <= fire_cnt + PE_TRIP_W'(1);
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.fu_done) begin
                  if (trip_hit) begin
                     state <= S_DRAIN;
                  end else begin
                     a_ready <= 1'b1;
                     b_ready <= !cfg0.b_const;
                     state   <= S_RUN;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_last) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done <= 1'b1;
            end
            default: state <= S_CFG;
         endcase
      end
   end

   assign bus.cfg_ready   = cfg_ready;
   assign bus.cfgd        = cfgd;
   assign bus.a_ready     = a_ready;
   assign bus.b_ready     = b_ready;
   assign bus.fu_in_valid = issue;
   assign bus.fu_in_a     = a_reg;
   assign bus.fu_in_b     = cfg0.b_const ? b_cst : b_reg;
   assign bus.fu_op       = cfg0.op;
   assign bus.out_valid   = !q_empty;
   assign bus.out_data    = q_empty ? '0 : q_head;
   assign bus.done        = done;

`ifdef PE_FU_CTRL_PERF_EN
   logic [31:0] perf_fire;
   logic [31:0] perf_stall;
   logic        stall;

   assign stall = (state == S_RUN) && ops_ready && !(bus.fu_ready && !q_full);

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         perf_fire  <= '0;
         perf_stall <= '0;
      end else begin
         if (issue && (perf_fire != '1))  perf_fire  <= perf_fire + 32'(1);
         if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'(1);
      end
   end

   assign bus.perf_fire  = perf_fire;
   assign bus.perf_stall = perf_stall;
`endif

endmodule

// File: tb/tb_pe_fu_ctrl.sv
// Self-checking bench for pe_fu_ctrl: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_pe_fu_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic        fu_en        = 1'b1;
   logic        fu_auto_done = 1'b0;
   logic [31:0] fu_auto_out  = '0;
   logic        fu_inj_done  = 1'b0;
   logic [31:0] fu_inj_out   = '0;

   logic [31:0] dir_a [3];
   logic [31:0] dir_b [3];
   logic [31:0] got_q [$];

   typedef struct {
      logic [31:0] cfg0;
      logic [31:0] cfg1;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  exp_op;
      logic [31:0] exp_fu_b;
      logic [31:0] exp_out;
      logic        exp_b_ready;
   } vec_t;
   vec_t vecs [5];

   pe_fu_ctrl_if #(.DATA_WIDTH(32)) bus ();

   pe_fu_ctrl #(.DATA_WIDTH(32), .OUT_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Behavioural FU: returns a+b one cycle after each issue.
   always @(posedge clk) begin
      fu_auto_done <= bus.fu_in_valid && fu_en;
      fu_auto_out  <= bus.fu_in_a + bus.fu_in_b;
   end
   assign bus.fu_done = fu_auto_done || fu_inj_done;
   assign bus.fu_out  = fu_inj_done ? fu_inj_out : fu_auto_out;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic chkb(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.cfg_valid = 1'b0; bus.cfg_data = '0;
      bus.a_valid = 1'b0;   bus.a_data = '0;
      bus.b_valid = 1'b0;   bus.b_data = '0;
      bus.fu_ready = 1'b1;  bus.out_ready = 1'b1;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   task automatic do_cfg(input logic [31:0] w0, input logic [31:0] w1);
      bus.cfg_valid = 1'b1; bus.cfg_data = w0;
      tick();
      bus.cfg_data = w1;
      tick();
      bus.cfg_valid = 1'b0; bus.cfg_data = '0;
   endtask

   // One operand pair through a freshly configured PE.
   task automatic run_vec(input int i);
      do_clear();
      do_cfg(vecs[i].cfg0, vecs[i].cfg1);
      bus.a_valid = 1'b1; bus.a_data = vecs[i].a;
      bus.b_valid = 1'b1; bus.b_data = vecs[i].b;
      #1;
      chkb($sformatf("vec%0d_b_ready", i), bus.b_ready, vecs[i].exp_b_ready);
      tick();
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      #1;
      chkb($sformatf("vec%0d_issue", i), bus.fu_in_valid, 1'b1);
      chk($sformatf("vec%0d_fu_a", i), bus.fu_in_a, vecs[i].a);
      chk($sformatf("vec%0d_fu_b", i), bus.fu_in_b, vecs[i].exp_fu_b);
      chk($sformatf("vec%0d_fu_op", i), 32'(bus.fu_op), 32'(vecs[i].exp_op));
      tick();
      tick();
      #1;
      chkb($sformatf("vec%0d_out_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_out);
      chkb($sformatf("vec%0d_rerun_a", i), bus.a_ready, 1'b1);
      chkb($sformatf("vec%0d_rerun_b", i), bus.b_ready, vecs[i].exp_b_ready);
      tick();
   endtask

   // Trip-bounded traffic checked against operand/result queues.
   task automatic run_traffic(input int trip, input logic [3:0] op, input bit rnd);
      logic [31:0] a_q [$];
      logic [31:0] b_q [$];
      logic [31:0] e_q [$];
      logic [31:0] ea, eb;
      int issued = 0, popped = 0, last_pop = -10, ai = 0, bi = 0;
      bit fin = 1'b0;
      got_q.delete();
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         if (rnd) begin
            bus.a_valid   = 1'($urandom_range(0, 1));
            bus.a_data    = $urandom;
            bus.b_valid   = 1'($urandom_range(0, 1));
            bus.b_data    = $urandom;
            bus.fu_ready  = ($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 1));
         end else begin
            bus.a_valid   = (ai < 3);
            bus.a_data    = dir_a[ai % 3];
            bus.b_valid   = (bi < 3);
            bus.b_data    = dir_b[bi % 3];
            bus.fu_ready  = 1'b1;
            bus.out_ready = 1'b1;
         end
         #1;
         if (bus.done) begin
            chk("done_pops", 32'(popped), 32'(trip));
            chk("done_issues", 32'(issued), 32'(trip));
            chk("done_latency", 32'(cyc), 32'(last_pop + 1));
            chkb("done_a_ready", bus.a_ready, 1'b0);
            chkb("done_b_ready", bus.b_ready, 1'b0);
            chkb("done_cfg_ready", bus.cfg_ready, 1'b0);
            chkb("done_out_valid", bus.out_valid, 1'b0);
            fin = 1'b1;
         end else begin
            if (bus.fu_in_valid) begin
               checks++;
               if (a_q.size() == 0 || b_q.size() == 0 || issued >= trip) begin
                  errors++;
                  $display("FAIL spurious_issue issued=%0d trip=%0d a_q=%0d b_q=%0d",
                           issued, trip, a_q.size(), b_q.size());
               end else begin
                  ea = a_q.pop_front();
                  eb = b_q.pop_front();
                  chk("issue_a", bus.fu_in_a, ea);
                  chk("issue_b", bus.fu_in_b, eb);
                  chk("issue_op", 32'(bus.fu_op), 32'(op));
                  e_q.push_back(ea + eb);
               end
               issued++;
            end
            if (bus.a_valid && bus.a_ready) begin a_q.push_back(bus.a_data); ai++; end
            if (bus.b_valid && bus.b_ready) begin b_q.push_back(bus.b_data); bi++; end
            if (bus.out_valid && bus.out_ready) begin
               checks++;
               if (e_q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_out got=0x%0h expected=none", bus.out_data);
               end else begin
                  ea = e_q.pop_front();
                  checks--;
                  chk("out_data", bus.out_data, ea);
               end
               got_q.push_back(bus.out_data);
               popped++;
               last_pop = cyc;
            end
            checks++;
            if (issued - popped > 4) begin
               errors++;
               $display("FAIL occupancy got=%0d limit=4", issued - popped);
            end
         end
         tick();
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL traffic_timeout got=done_low expected=done_high");
      end
      idle_inputs();
   endtask

   // One pair latched while fu_ready is low for n cycles, then issued.
   task automatic stall_seq(input int n);
      bus.fu_ready = 1'b0; bus.out_ready = 1'b1;
      bus.a_valid = 1'b1; bus.a_data = 32'(n + 3);
      bus.b_valid = 1'b1; bus.b_data = 32'(n + 40);
      tick();
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         #1;
         chkb("stall_no_issue", bus.fu_in_valid, 1'b0);
         chkb("stall_a_ready", bus.a_ready, 1'b0);
         tick();
      end
      bus.fu_ready = 1'b1;
      #1;
      chkb("stall_release_issue", bus.fu_in_valid, 1'b1);
      tick();
      tick();
      tick();
   endtask

   initial begin
      int n;
      logic [31:0] w0;
      logic [3:0]  rop;

      vecs[0] = '{32'h0000_0001, 32'h55,        32'd1,         32'd10,     4'h1, 32'd10,        32'd11,        1'b1};
      vecs[1] = '{32'h0000_0012, 32'd7,         32'd5,         32'd99,     4'h2, 32'd7,         32'd12,        1'b0};
      vecs[2] = '{32'h0000_000F, 32'h0,         32'hFFFF_FFFF, 32'd1,      4'hF, 32'd1,         32'd0,         1'b1};
      vecs[3] = '{32'h0000_0019, 32'hDEAD_BEEF, 32'h10,        32'h1234,   4'h9, 32'hDEAD_BEEF, 32'hDEAD_BEFF, 1'b0};
      vecs[4] = '{32'h0000_FF37, 32'h100,       32'h200,       32'h5,      4'h7, 32'h100,       32'h300,       1'b0};
      dir_a = '{32'd1, 32'd2, 32'd3};
      dir_b = '{32'd10, 32'd20, 32'd30};

      bus.clear = 1'b0;
      idle_inputs();
      repeat (3) tick();
      chkb("rst_cfg_ready", bus.cfg_ready, 1'b1);
      chkb("rst_cfgd", bus.cfgd, 1'b0);
      chkb("rst_a_ready", bus.a_ready, 1'b0);
      chkb("rst_b_ready", bus.b_ready, 1'b0);
      chkb("rst_fu_in_valid", bus.fu_in_valid, 1'b0);
      chk("rst_fu_in_a", bus.fu_in_a, 32'd0);
      chk("rst_fu_in_b", bus.fu_in_b, 32'd0);
      chk("rst_fu_op", 32'(bus.fu_op), 32'd0);
      chkb("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chkb("rst_done", bus.done, 1'b0);
      rst = 1'b0;
      tick();

      // Trip count of 3 with the directed operand stream.
      chkb("trip_cfgd_before", bus.cfgd, 1'b0);
      do_cfg(32'h0000_0301, 32'h55);
      chkb("trip_cfgd_after", bus.cfgd, 1'b1);
      run_traffic(3, 4'h1, 1'b0);
      checks++;
      if (got_q.size() != 3) begin
         errors++;
         $display("FAIL trip_result_count got=%0d expected=3", got_q.size());
      end else begin
         checks--;
         chk("trip_out0", got_q[0], 32'd11);
         chk("trip_out1", got_q[1], 32'd22);
         chk("trip_out2", got_q[2], 32'd33);
      end
      tick();
      #1;
      chkb("trip_done_held", bus.done, 1'b1);
      chkb("trip_a_ready_held", bus.a_ready, 1'b0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // Output backpressure: four reserved slots, then one more per pop.
      do_clear();
      do_cfg(32'h0, 32'h0);
      bus.out_ready = 1'b0; bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         bus.a_data = $urandom; bus.b_data = $urandom;
         #1;
         if (bus.fu_in_valid) n++;
         tick();
      end
      chk("bp_issues", 32'(n), 32'd4);
      chkb("bp_out_valid", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      #1;
      if (bus.fu_in_valid) n++;
      tick();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.fu_in_valid) n++;
         tick();
      end
      chk("bp_issues_after_pop", 32'(n), 32'd5);
      idle_inputs();

      do_clear();
      do_cfg(32'h0, 32'h0);
      stall_seq(5);

      // Clear while an op is in flight with two results queued.
      do_clear();
      do_cfg(32'h0, 32'h0);
      bus.out_ready = 1'b0; bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
         #1;
         if (bus.fu_in_valid) begin
            n++;
            if (n == 3) fu_en = 1'b0;
         end
         tick();
      end
      chk("clr_setup_issues", 32'(n), 32'd3);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      #1;
      chkb("clr_queue_before", bus.out_valid, 1'b1);
      do_clear();
      #1;
      chkb("clr_out_valid", bus.out_valid, 1'b0);
      chkb("clr_cfgd", bus.cfgd, 1'b0);
      chkb("clr_cfg_ready", bus.cfg_ready, 1'b1);
      chkb("clr_a_ready", bus.a_ready, 1'b0);
      fu_inj_done = 1'b1; fu_inj_out = 32'hBAD0_BAD0;
      tick();
      fu_inj_done = 1'b0;
      tick();
      #1;
      chkb("clr_late_done_ignored", bus.out_valid, 1'b0);
      fu_en = 1'b1;
      idle_inputs();

      for (int r = 0; r < 6; r++) begin
         n   = int'($urandom_range(1, 12));
         rop = 4'($urandom_range(0, 15));
         w0  = (32'(n) << 8) | 32'(rop);
         do_clear();
         do_cfg(w0, $urandom);
         run_traffic(n, rop, 1'b1);
      end

`ifdef PE_FU_CTRL_PERF_EN
      do_clear();
      #1;
      chk("perf_fire_cleared", bus.perf_fire, 32'd0);
      chk("perf_stall_cleared", bus.perf_stall, 32'd0);
      do_cfg(32'h0, 32'h0);
      stall_seq(4);
      stall_seq(0);
      stall_seq(0);
      #1;
      chk("perf_fire", bus.perf_fire, 32'd3);
      chk("perf_stall", bus.perf_stall, 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1);
   end

endmodule
